// File: rtl/mccu_fsm.sv
// rtl/mccu_fsm.sv - multicycle MIPS-subset control unit (IF/ID/EXE/MEM/WB sequencer and decoder)
module mccu_fsm (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  input  logic       i_z,
  output logic       o_wpc,
  output logic       o_wir,
  output logic       o_wmem,
  output logic       o_wreg,
  output logic       o_iord,
  output logic       o_regrt,
  output logic       o_m2reg,
  output logic       o_jal,
  output logic       o_sext,
  output logic       o_shift,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [3:0] o_aluc,
  output logic [1:0] o_pcsource,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // instruction class decode
  logic       w_r_alu;
  logic [3:0] w_r_aluc;
  logic       w_r_shift;
  logic       w_i_alu;
  logic [3:0] w_i_aluc;
  logic       w_jr;
  logic       w_j;
  logic       w_jal_op;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_bne;
  logic       w_valid;

  // raw per-state controls before the reset mask on the write enables
  logic       w_wpc;
  logic       w_wir;
  logic       w_wmem;
  logic       w_wreg;

  // State register; reset aborts any instruction straight back to fetch
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Decode op/func into instruction classes and their ALU operation codes
  always_comb begin
    w_r_alu   = 1'b0;
    w_r_aluc  = 4'b0000;
    w_r_shift = 1'b0;
    w_i_alu   = 1'b0;
    w_i_aluc  = 4'b0000;
    w_jr      = 1'b0;
    w_j       = 1'b0;
    w_jal_op  = 1'b0;
    w_lw      = 1'b0;
    w_sw      = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    if (i_op == 6'b000000) begin
      case (i_func)
        6'b100000: begin w_r_alu = 1'b1; w_r_aluc = 4'b0000; end
        6'b100010: begin w_r_alu = 1'b1; w_r_aluc = 4'b0100; end
        6'b100100: begin w_r_alu = 1'b1; w_r_aluc = 4'b0001; end
        6'b100101: begin w_r_alu = 1'b1; w_r_aluc = 4'b0101; end
        6'b100110: begin w_r_alu = 1'b1; w_r_aluc = 4'b0010; end
        6'b000000: begin w_r_alu = 1'b1; w_r_aluc = 4'b0011; w_r_shift = 1'b1; end
        6'b000010: begin w_r_alu = 1'b1; w_r_aluc = 4'b0111; w_r_shift = 1'b1; end
        6'b000011: begin w_r_alu = 1'b1; w_r_aluc = 4'b1111; w_r_shift = 1'b1; end
        6'b001000: w_jr = 1'b1;
        default:   ;
      endcase
    end else begin
      case (i_op)
        6'b001000: begin w_i_alu = 1'b1; w_i_aluc = 4'b0000; end
        6'b001100: begin w_i_alu = 1'b1; w_i_aluc = 4'b0001; end
        6'b001101: begin w_i_alu = 1'b1; w_i_aluc = 4'b0101; end
        6'b001110: begin w_i_alu = 1'b1; w_i_aluc = 4'b0010; end
        6'b001111: begin w_i_alu = 1'b1; w_i_aluc = 4'b0110; end
        6'b100011: w_lw     = 1'b1;
        6'b101011: w_sw     = 1'b1;
        6'b000100: w_beq    = 1'b1;
        6'b000101: w_bne    = 1'b1;
        6'b000010: w_j      = 1'b1;
        6'b000011: w_jal_op = 1'b1;
        default:   ;
      endcase
    end
    w_valid = w_r_alu | w_i_alu | w_lw | w_sw | w_beq | w_bne;
  end

  // Next-state and per-cycle datapath controls from state and decoded instruction
  always_comb begin
    w_next       = S_IF;
    w_wpc        = 1'b0;
    w_wir        = 1'b0;
    w_wmem       = 1'b0;
    w_wreg       = 1'b0;
    o_iord       = 1'b0;
    o_regrt      = 1'b0;
    o_m2reg      = 1'b0;
    o_jal        = 1'b0;
    o_sext       = 1'b1;
    o_shift      = 1'b0;
    o_alusrca    = 1'b0;
    o_alusrcb    = 2'b00;
    o_aluc       = 4'b0000;
    o_pcsource   = 2'b00;
    case (r_state)
      S_IF: begin
        w_wir     = 1'b1;
        w_wpc     = 1'b1;
        o_alusrcb = 2'b01;
        w_next    = S_ID;
      end
      S_ID: begin
        // ALU computes the branch target now so EXE can use it from the ALU output reg
        o_alusrcb = 2'b11;
        if (w_j) begin
          w_wpc      = 1'b1;
          o_pcsource = 2'b11;
        end else if (w_jal_op) begin
          w_wpc      = 1'b1;
          w_wreg     = 1'b1;
          o_jal      = 1'b1;
          o_pcsource = 2'b11;
        end else if (w_jr) begin
          w_wpc      = 1'b1;
          o_pcsource = 2'b10;
        end else if (w_valid) begin
          w_next     = S_EXE;
        end
      end
      S_EXE: begin
        o_alusrca = 1'b1;
        if (w_r_alu) begin
          o_aluc  = w_r_aluc;
          o_shift = w_r_shift;
          w_next  = S_WB;
        end else if (w_i_alu) begin
          o_alusrcb = 2'b10;
          o_sext    = (i_op == 6'b001000);
          o_aluc    = w_i_aluc;
          w_next    = S_WB;
        end else if (w_lw || w_sw) begin
          o_alusrcb = 2'b10;
          w_next    = S_MEM;
        end else if (w_beq) begin
          o_aluc     = 4'b0100;
          w_wpc      = i_z;
          o_pcsource = 2'b01;
        end else if (w_bne) begin
          o_aluc     = 4'b0100;
          w_wpc      = ~i_z;
          o_pcsource = 2'b01;
        end
      end
      S_MEM: begin
        o_iord = 1'b1;
        w_wmem = w_sw;
        if (w_lw) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_wreg  = 1'b1;
        o_regrt = (i_op != 6'b000000);
        o_m2reg = w_lw;
      end
      default: w_next = S_IF;
    endcase
  end

  // Write enables are held off for as long as reset is asserted
  assign o_wpc   = w_wpc  & i_rst;
  assign o_wir   = w_wir  & i_rst;
  assign o_wmem  = w_wmem & i_rst;
  assign o_wreg  = w_wreg & i_rst;
  assign o_state = r_state;

endmodule

// File: tb/tb_mccu_fsm.sv
// tb/tb_mccu_fsm.sv - randomized self-checking bench for mccu_fsm against an instruction-level model
module tb_mccu_fsm;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_op;
  logic [5:0] i_func;
  logic       i_z;
  logic       o_wpc, o_wir, o_wmem, o_wreg, o_iord, o_regrt, o_m2reg, o_jal;
  logic       o_sext, o_shift, o_alusrca;
  logic [1:0] o_alusrcb;
  logic [3:0] o_aluc;
  logic [1:0] o_pcsource;
  logic [2:0] o_state;

  int n_vec;
  int n_err;

  mccu_fsm u_dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_op       (i_op),
    .i_func     (i_func),
    .i_z        (i_z),
    .o_wpc      (o_wpc),
    .o_wir      (o_wir),
    .o_wmem     (o_wmem),
    .o_wreg     (o_wreg),
    .o_iord     (o_iord),
    .o_regrt    (o_regrt),
    .o_m2reg    (o_m2reg),
    .o_jal      (o_jal),
    .o_sext     (o_sext),
    .o_shift    (o_shift),
    .o_alusrca  (o_alusrca),
    .o_alusrcb  (o_alusrcb),
    .o_aluc     (o_aluc),
    .o_pcsource (o_pcsource),
    .o_state    (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int C_R    = 0;
  localparam int C_JR   = 1;
  localparam int C_IALU = 2;
  localparam int C_LW   = 3;
  localparam int C_SW   = 4;
  localparam int C_BEQ  = 5;
  localparam int C_BNE  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_UND  = 9;

  // packed observation: {wpc,wir,wmem,wreg,iord,regrt,m2reg,jal,sext,shift,alusrca,alusrcb,aluc,pcsource}
  function automatic logic [18:0] obs_vec();
    return {o_wpc, o_wir, o_wmem, o_wreg, o_iord, o_regrt, o_m2reg, o_jal,
            o_sext, o_shift, o_alusrca, o_alusrcb, o_aluc, o_pcsource};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'b001000) return C_JR;
      if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                     6'b000000, 6'b000010, 6'b000011}) return C_R;
      return C_UND;
    end
    case (op)
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: return C_IALU;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_UND;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] key;
    key = (op == 6'd0) ? fn : op;
    if (op == 6'd0) begin
      case (key)
        6'b100000: return 4'b0000;
        6'b100010: return 4'b0100;
        6'b100100: return 4'b0001;
        6'b100101: return 4'b0101;
        6'b100110: return 4'b0010;
        6'b000000: return 4'b0011;
        6'b000010: return 4'b0111;
        default:   return 4'b1111;
      endcase
    end
    case (key)
      6'b001100: return 4'b0001;
      6'b001101: return 4'b0101;
      6'b001110: return 4'b0010;
      6'b001111: return 4'b0110;
      default:   return 4'b0000;
    endcase
  endfunction

  // number of cycles an instruction occupies, from fetch to the next fetch
  function automatic int instr_len(input int c);
    case (c)
      C_LW:               return 5;
      C_SW, C_R, C_IALU:  return 4;
      C_BEQ, C_BNE:       return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k <= 2) return 3'(k);
    if ((c == C_LW || c == C_SW) && k == 3) return 3'd3;
    return 3'd4;
  endfunction

  // expected controls for cycle k (0 = fetch) of an instruction
  function automatic logic [18:0] exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                          input int k, input logic z);
    int         c;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, srca;
    logic [1:0] srcb, pcs;
    logic [3:0] aluc;
    c = classify(op, fn);
    {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, srca} = '0;
    sext = 1'b1; srcb = 2'b00; pcs = 2'b00; aluc = 4'b0000;
    if (k == 0) begin
      wpc = 1'b1; wir = 1'b1; srcb = 2'b01;
    end else if (k == 1) begin
      srcb = 2'b11;
      if (c == C_J)   begin wpc = 1'b1; pcs = 2'b11; end
      if (c == C_JAL) begin wpc = 1'b1; wreg = 1'b1; jal = 1'b1; pcs = 2'b11; end
      if (c == C_JR)  begin wpc = 1'b1; pcs = 2'b10; end
    end else if (k == 2) begin
      srca = 1'b1;
      case (c)
        C_R:    begin aluc = alu_code(op, fn); shift = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3); end
        C_IALU: begin srcb = 2'b10; sext = (op == 6'b001000); aluc = alu_code(op, fn); end
        C_LW, C_SW: srcb = 2'b10;
        C_BEQ:  begin aluc = 4'b0100; wpc = z;  pcs = 2'b01; end
        C_BNE:  begin aluc = 4'b0100; wpc = !z; pcs = 2'b01; end
        default: ;
      endcase
    end else if (k == 3 && (c == C_LW || c == C_SW)) begin
      iord = 1'b1; wmem = (c == C_SW);
    end else begin
      wreg = 1'b1; regrt = (op != 6'd0); m2reg = (c == C_LW);
    end
    return {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, srca, srcb, aluc, pcs};
  endfunction

  // checks one cycle; entered just after a posedge, leaves just after the next one
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input int k, input logic z);
    int c;
    c = classify(op, fn);
    i_z = z;
    @(negedge i_clk);
    chk($sformatf("ctl op=%b fn=%b k=%0d", op, fn, k), 32'(obs_vec()), 32'(exp_vec(op, fn, k, z)));
    chk($sformatf("state op=%b fn=%b k=%0d", op, fn, k), 32'(o_state), 32'(exp_state(c, k)));
    @(posedge i_clk);
    #1;
  endtask

  // zmode: 0/1 fixed flag, 2 random each cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    int n;
    n = instr_len(classify(op, fn));
    i_op   = op;
    i_func = fn;
    for (int k = 0; k < n; k++) begin
      step(op, fn, k, (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode));
    end
  endtask

  logic [5:0] ops_tab [16];
  logic [5:0] fns_tab [12];

  initial begin
    logic [18:0] ev;
    logic [5:0]  op;
    logic [5:0]  fn;
    n_vec = 0;
    n_err = 0;
    i_rst = 1'b0;
    i_op = 6'd0;
    i_func = 6'd0;
    i_z = 1'b0;

    ops_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                6'b001110, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b000010, 6'b000011, 6'b111111, 6'b010000};
    fns_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b000000,
                6'b000010, 6'b000011, 6'b001000, 6'b000001, 6'b111111, 6'b101010};

    // reset held three cycles: fetch decode visible, enables masked
    ev = exp_vec(6'd0, 6'd0, 0, 1'b0) & ~19'h60000;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_ctl", 32'(obs_vec()), 32'(ev));
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    // directed instructions
    run_instr(6'b000000, 6'b100000, 2);   // add
    run_instr(6'b100011, 6'h15, 2);       // lw
    run_instr(6'b000100, 6'h00, 1);       // beq taken
    run_instr(6'b000100, 6'h00, 0);       // beq not taken
    run_instr(6'b000101, 6'h00, 1);       // bne not taken
    run_instr(6'b000101, 6'h00, 0);       // bne taken
    run_instr(6'b000011, 6'h2a, 2);       // jal
    run_instr(6'b000000, 6'b001000, 2);   // jr
    run_instr(6'b001111, 6'h00, 2);       // lui

    // sw aborted by reset in the memory cycle
    i_op = 6'b101011;
    i_func = 6'h07;
    for (int k = 0; k < 3; k++) step(6'b101011, 6'h07, k, 1'b0);
    @(negedge i_clk);
    chk("sw_mem_wmem", 32'(o_wmem), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("abort_wmem", 32'(o_wmem), 32'd0);
    chk("abort_state", 32'(o_state), 32'd0);
    chk("abort_wpc", 32'(o_wpc), 32'd0);
    @(posedge i_clk);
    #1;
    chk("abort_hold_wmem", 32'(o_wmem), 32'd0);
    chk("abort_hold_state", 32'(o_state), 32'd0);
    i_rst = 1'b1;

    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      op = ops_tab[$urandom_range(0, 15)];
      fn = (op == 6'd0) ? fns_tab[$urandom_range(0, 11)] : 6'($urandom);
      run_instr(op, fn, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
